// File: rtl/microwave_ctrl.sv
// Microwave front-panel controller: keypad debounce, button edge detection,
// IDLE/SET/COOK/PAUSE sequencing, timer strobes and door-gated magnetron enable.
// Handshake: load_en, dec_en, timer_clr and done are single-cycle strobes with
// no back-pressure; key_code is only meaningful in the cycle load_en is high.
module microwave_ctrl #(
  parameter int TICKS_PER_SEC  = 50,
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] key_code,
  output logic       load_en,
  output logic       dec_en,
  output logic       timer_clr,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SET   = 2'b01,
    COOK  = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t        st;
  logic          start_r, stop_r, clear_r;
  logic          start_ev, stop_ev, clear_ev;
  logic [9:0]    key_prev;
  logic [CW-1:0] db_cnt;
  logic          db_locked;
  logic          key_valid;
  logic          key_same;
  logic [CW-1:0] run_len;
  logic          key_ev;
  logic [3:0]    key_bcd;
  logic [PW-1:0] presc;

  // Register each active-low button once so a press is seen as a 1->0 step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_r <= 1'b1;
      stop_r  <= 1'b1;
      clear_r <= 1'b1;
    end else begin
      start_r <= startn;
      stop_r  <= stopn;
      clear_r <= clearn;
    end
  end

  assign start_ev = start_r & ~startn;
  assign stop_ev  = stop_r  & ~stopn;
  assign clear_ev = clear_r & ~clearn;

  // Length of the current run of one identical one-hot keypad value, and its BCD code.
  always_comb begin
    key_valid = ($countones(keypad) == 1);
    key_same  = (keypad == key_prev) && (db_cnt != '0);
    run_len   = key_same ? (db_cnt + CW'(1)) : CW'(1);
    key_ev    = !db_locked && key_valid && (run_len >= CW'(DEBOUNCE_TICKS));
    key_bcd   = '0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_bcd = 4'(i);
    end
  end

  // Debouncer: accept a stable key once, then stay locked until the pad is quiet long enough.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db_locked <= 1'b0;
      db_cnt    <= '0;
      key_prev  <= '0;
    end else if (db_locked) begin
      if (keypad == '0) begin
        if (db_cnt + CW'(1) >= CW'(DEBOUNCE_TICKS)) begin
          db_locked <= 1'b0;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end else if (key_ev) begin
      db_locked <= 1'b1;
      db_cnt    <= '0;
    end else if (key_valid) begin
      db_cnt   <= run_len;
      key_prev <= keypad;
    end else begin
      db_cnt <= '0;
    end
  end

  // Main sequencer with registered strobes and the one-second prescaler.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      load_en   <= 1'b0;
      dec_en    <= 1'b0;
      timer_clr <= 1'b0;
      done      <= 1'b0;
      key_code  <= '0;
      presc     <= '0;
    end else begin
      load_en   <= 1'b0;
      dec_en    <= 1'b0;
      timer_clr <= 1'b0;
      done      <= 1'b0;
      if (clear_ev) begin
        st        <= IDLE;
        timer_clr <= 1'b1;
        presc     <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (key_ev) begin
              load_en  <= 1'b1;
              key_code <= key_bcd;
              st       <= SET;
            end
          end
          SET: begin
            // A start press is consumed even when the door or timer blocks it.
            if (start_ev) begin
              if (door_closed && !timer_zero) begin
                st    <= COOK;
                presc <= '0;
              end
            end else if (key_ev) begin
              load_en  <= 1'b1;
              key_code <= key_bcd;
            end
          end
          COOK: begin
            if (stop_ev || !door_closed) begin
              st <= PAUSE;
            end else if (timer_zero) begin
              st   <= IDLE;
              done <= 1'b1;
            end else if (presc == PW'(TICKS_PER_SEC - 1)) begin
              presc  <= '0;
              dec_en <= 1'b1;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (start_ev && door_closed) st <= COOK;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign state  = st;
  assign mag_on = (st == COOK) && door_closed;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Testbench for microwave_ctrl: directed scenarios with randomized details
// followed by a random soak, checked every cycle against a behavioural model.
module tb_microwave_ctrl;

  localparam int T = 4;
  localparam int D = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed, timer_zero;
  logic [3:0] key_code;
  logic       load_en, dec_en, timer_clr, mag_on, done;
  logic [1:0] state;

  microwave_ctrl #(.TICKS_PER_SEC(T), .DEBOUNCE_TICKS(D)) dut (
    .clock(clock), .resetn(resetn), .keypad(keypad), .startn(startn),
    .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
    .timer_zero(timer_zero), .key_code(key_code), .load_en(load_en),
    .dec_en(dec_en), .timer_clr(timer_clr), .mag_on(mag_on), .done(done),
    .state(state)
  );

  // Clock
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_load = 0, n_dec = 0, n_clr = 0, n_done = 0;

  // Expected per-cycle response: {state[9:8], load[7], key[6:3], dec[2], clr[1], done[0]}
  logic [9:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: last D keypad samples kept as a history window;
  // states named by their output codes; cook time as active cycles modulo T.
  int         m_state;
  bit         m_ps, m_pp, m_pc, m_lock;
  logic [9:0] kh[$];
  int         m_acc;
  logic [3:0] m_key;

  always @(posedge clock or negedge resetn) begin
    bit s_ev, p_ev, c_ev, k_ev, all_same, all_zero;
    bit ld, dc, cl, dn;
    int kval;
    if (!resetn) begin
      m_state = 0; m_ps = 1; m_pp = 1; m_pc = 1; m_lock = 0;
      kh.delete(); m_acc = 0; m_key = '0;
    end else begin
      s_ev = m_ps && !startn;
      p_ev = m_pp && !stopn;
      c_ev = m_pc && !clearn;
      m_ps = startn; m_pp = stopn; m_pc = clearn;
      kh.push_back(keypad);
      if (kh.size() > D) void'(kh.pop_front());
      all_same = (kh.size() == D);
      all_zero = all_same;
      foreach (kh[i]) begin
        if (kh[i] != kh[0]) all_same = 0;
        if (kh[i] != '0) all_zero = 0;
      end
      k_ev = 0;
      kval = 0;
      if (m_lock) begin
        if (all_zero) m_lock = 0;
      end else if (all_same && $countones(kh[0]) == 1) begin
        k_ev = 1;
        m_lock = 1;
        for (int i = 0; i < 10; i++) if (kh[0][i]) kval = i;
      end
      ld = 0; dc = 0; cl = 0; dn = 0;
      if (c_ev) begin
        m_state = 0; cl = 1; m_acc = 0;
      end else begin
        case (m_state)
          0: if (k_ev) begin ld = 1; m_key = 4'(kval); m_state = 1; end
          1: begin
            if (s_ev) begin
              if (door_closed && !timer_zero) begin m_state = 2; m_acc = 0; end
            end else if (k_ev) begin
              ld = 1; m_key = 4'(kval);
            end
          end
          2: begin
            if (p_ev || !door_closed) m_state = 3;
            else if (timer_zero) begin m_state = 0; dn = 1; end
            else begin
              m_acc++;
              if (m_acc == T) begin dc = 1; m_acc = 0; end
            end
          end
          3: if (s_ev && door_closed) m_state = 2;
          default: ;
        endcase
      end
      exp_q.push_back({2'(m_state), ld, m_key, dc, cl, dn});
    end
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  always @(negedge clock) begin
    logic [9:0] e;
    if (!resetn) begin
      exp_q.delete();
      check("rst_state", state, 0);
      check("rst_load_en", load_en, 0);
      check("rst_dec_en", dec_en, 0);
      check("rst_timer_clr", timer_clr, 0);
      check("rst_done", done, 0);
      check("rst_mag_on", mag_on, 0);
      check("rst_key_code", key_code, 0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("state", state, e[9:8]);
      check("load_en", load_en, e[7]);
      if (e[7]) check("key_code", key_code, e[6:3]);
      check("dec_en", dec_en, e[2]);
      check("timer_clr", timer_clr, e[1]);
      check("done", done, e[0]);
      check("mag_on", mag_on, (e[9:8] == 2'b10) && door_closed);
    end
    if (resetn) begin
      if (load_en)   n_load++;
      if (dec_en)    n_dec++;
      if (timer_clr) n_clr++;
      if (done)      n_done++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_key(input int k, input int hold);
    keypad = '0;
    keypad[k] = 1'b1;
    tick(hold);
    keypad = '0;
    tick(D + 1);
  endtask

  // which: 0 start, 1 stop, 2 clear
  task automatic press_btn(input int which);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    tick(1);
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    tick(1);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int base;
    int waited;
    int r;
    resetn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_zero = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);

    // 1: keys 4,4,7 then start and cook
    base = n_load;
    press_key(4, 5);
    press_key(4, 5);
    press_key(7, 5);
    check("s1_loads", n_load - base, 3);
    press_btn(0);
    tick(3 * T + $urandom_range(0, 3));

    // 2: door open during cook, then resume
    door_closed = 1'b0;
    tick(10);
    door_closed = 1'b1;
    tick(2);
    press_btn(0);
    tick($urandom_range(5, 12));

    // 3: chatter then hold, and a very long hold
    press_btn(2);
    base = n_load;
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
      tick(1);
    end
    keypad = 10'b0000100000;
    tick(3);
    keypad = '0;
    tick(D + 1);
    check("s3_chatter_loads", n_load - base, 1);
    base = n_load;
    press_key(5, 200);
    check("s3_long_hold_loads", n_load - base, 1);

    // 4: blocked starts in SET, then cook, stop, resume
    door_closed = 1'b0;
    press_btn(0);
    door_closed = 1'b1;
    timer_zero = 1'b1;
    press_btn(0);
    timer_zero = 1'b0;
    press_key($urandom_range(0, 9), $urandom_range(D, 6));
    press_btn(0);
    base = n_dec;
    waited = 0;
    while ((n_dec - base) < 3 && waited < 100) begin
      tick(1);
      waited++;
    end
    check("s4_three_dec_seen", (n_dec - base) >= 3, 1);
    press_btn(1);
    tick(3);
    press_btn(0);
    tick($urandom_range(2, 9));

    // 5: clear in COOK, in SET, and together with start
    base = n_clr;
    press_btn(2);
    press_key($urandom_range(0, 9), $urandom_range(D, 6));
    press_btn(2);
    press_key($urandom_range(0, 9), $urandom_range(D, 6));
    startn = 1'b0; clearn = 1'b0;
    tick(1);
    startn = 1'b1; clearn = 1'b1;
    tick(2);
    check("s5_clears", n_clr - base, 3);

    // 6: keys ignored in COOK, timer_zero finishes, async reset mid-cook
    press_key($urandom_range(1, 9), 3);
    press_btn(0);
    tick(2);
    base = n_load;
    press_key(3, 3);
    press_key(5, 3);
    press_key(0, 3);
    check("s6_cook_keys_ignored", n_load - base, 0);
    base = n_done;
    timer_zero = 1'b1;
    tick(2);
    timer_zero = 1'b0;
    tick(1);
    check("s6_done", n_done - base, 1);
    press_key($urandom_range(1, 9), 3);
    press_btn(0);
    tick($urandom_range(3, 7));
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_mag_on", mag_on, 0);
    check("async_strobes", {load_en, dec_en, timer_clr, done}, 0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    // Random soak
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5) keypad = '0;
        else if (r < 9) begin keypad = '0; keypad[$urandom_range(0, 9)] = 1'b1; end
        else begin keypad = '0; keypad[$urandom_range(0, 4)] = 1'b1; keypad[$urandom_range(5, 9)] = 1'b1; end
      end
      startn      = ($urandom_range(0, 5) != 0);
      stopn       = ($urandom_range(0, 24) != 0);
      clearn      = ($urandom_range(0, 59) != 0);
      timer_zero  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
      tick(1);
    end
    keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_zero = 1'b0;
    tick(3);
    @(negedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
